// File: rtl/weight_stream_if.sv
// Upstream weight-slice stream: the source offers one slice for all lanes,
// the scheduler accepts it and reports which group/depth slice it wants.
interface weight_stream_if #(
    parameter int DATA_WIDTH       = 16,
    parameter int KERNEL_SIZE_MAX  = 3,
    parameter int PARA_KERNEL      = 2,
    parameter int KERNEL_NUM_WIDTH = 8,
    parameter int DEPTH_WIDTH      = 6
);
    localparam int SLICE_W = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH;

    logic                        valid;
    logic                        ready;
    logic [SLICE_W-1:0]          data;
    logic [KERNEL_NUM_WIDTH-1:0] group;
    logic [DEPTH_WIDTH-1:0]      slice;

    modport master (output valid, data, input ready, group, slice);
    modport slave  (input valid, data, output ready, group, slice);
endinterface

// File: rtl/weight_update_scheduler.sv
// Sequences weight-RAM loads for the parallel conv layer: one slice per depth
// step per kernel group, pulled from the weight stream and written to all lanes.
module weight_update_scheduler #(
    parameter int DATA_WIDTH              = 16,
    parameter int KERNEL_SIZE_MAX         = 3,
    parameter int PARA_KERNEL             = 2,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 10,
    parameter int DEPTH_WIDTH             = 6,
    parameter int KERNEL_NUM_WIDTH        = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        init_start,
    input  logic [DEPTH_WIDTH-1:0]                      fm_depth,
    input  logic [KERNEL_NUM_WIDTH-1:0]                 kernel_num,
    input  logic                                        update_weight_ram,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] update_weight_ram_addr,
    weight_stream_if.slave                              src,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
    output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr,
    output logic                                        weight_wr_en,
    output logic                                        weight_data_done,
    output logic                                        all_groups_loaded,
    output logic                                        busy
);
    localparam int AW = WEIGHT_WRITE_ADDR_WIDTH;
    localparam int GW = KERNEL_NUM_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    state_t                          state, state_nxt;
    logic [KERNEL_NUM_WIDTH-1:0]     group;
    logic [GW-1:0]                   total;
    logic [DEPTH_WIDTH-1:0]          slice, depth;
    logic [PARA_KERNEL-1:0][AW-1:0]  base, addr;
    logic                            init_trig, upd_trig, trig, accept, last_beat, last_group;
    logic [GW-1:0]                   total_calc;

    // Groups are PARA_KERNEL kernels wide; an empty layer still loads one group.
    assign total_calc = ({1'b0, kernel_num} + GW'(PARA_KERNEL - 1)) / GW'(PARA_KERNEL);

    assign src.ready  = (state == LOAD);
    assign src.group  = group;
    assign src.slice  = slice;
    assign busy       = (state != IDLE);
    assign write_weight_data_addr = addr;
    assign last_group = ({1'b0, group} == total - GW'(1));

    always_comb begin
        init_trig = (state == IDLE) && init_start;
        upd_trig  = (state == IDLE) && !init_start && update_weight_ram
                    && weight_data_done && !all_groups_loaded;
        trig      = init_trig || upd_trig;
        accept    = (state == LOAD) && src.valid;
        last_beat = accept && (slice == depth - DEPTH_WIDTH'(1));
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = (fm_depth == '0) ? FINISH : LOAD;
            LOAD:    if (last_beat) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            group             <= '0;
            total             <= '0;
            slice             <= '0;
            depth             <= '0;
            base              <= '0;
            weight_data       <= '0;
            weight_wr_en      <= 1'b0;
            weight_data_done  <= 1'b0;
            all_groups_loaded <= 1'b0;
        end else begin
            weight_wr_en <= accept;
            if (accept) begin
                weight_data <= src.data;
                slice       <= slice + DEPTH_WIDTH'(1);
            end
            if (trig) begin
                weight_data_done <= 1'b0;
                depth            <= fm_depth;
                slice            <= '0;
            end
            if (init_trig) begin
                group             <= '0;
                base              <= '0;
                total             <= (kernel_num == '0) ? GW'(1) : total_calc;
                all_groups_loaded <= 1'b0;
            end else if (upd_trig) begin
                group <= group + KERNEL_NUM_WIDTH'(1);
                base  <= update_weight_ram_addr;
            end
            if (state == FINISH) begin
                weight_data_done <= 1'b1;
                if (last_group) all_groups_loaded <= 1'b1;
            end
        end
    end

    // Lane addresses wrap naturally at the RAM depth.
    for (genvar p = 0; p < PARA_KERNEL; p++) begin : g_lane
        always_ff @(posedge clk) begin
            if (!rst)        addr[p] <= '0;
            else if (accept) addr[p] <= base[p] + AW'(slice);
        end
    end
endmodule

// File: tb/tb_weight_update_scheduler.sv
// Scenario bench for weight_update_scheduler with a write scoreboard.
module tb_weight_update_scheduler;
    localparam int DW = 16, KS = 3, PK = 2, AW = 10, DEPW = 6, KNW = 8;
    localparam int SW = KS * KS * PK * DW;

    logic clk = 1'b0, rst = 1'b0, init_start = 1'b0, update_weight_ram = 1'b0;
    logic [DEPW-1:0]  fm_depth = '0;
    logic [KNW-1:0]   kernel_num = '0;
    logic [AW*PK-1:0] update_weight_ram_addr = '0;
    logic [SW-1:0]    weight_data;
    logic [AW*PK-1:0] write_weight_data_addr;
    logic weight_wr_en, weight_data_done, all_groups_loaded, busy;

    weight_stream_if #(.DATA_WIDTH(DW), .KERNEL_SIZE_MAX(KS), .PARA_KERNEL(PK),
                       .KERNEL_NUM_WIDTH(KNW), .DEPTH_WIDTH(DEPW)) src ();

    weight_update_scheduler #(.DATA_WIDTH(DW), .KERNEL_SIZE_MAX(KS), .PARA_KERNEL(PK),
        .WEIGHT_WRITE_ADDR_WIDTH(AW), .DEPTH_WIDTH(DEPW), .KERNEL_NUM_WIDTH(KNW)) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .fm_depth(fm_depth),
        .kernel_num(kernel_num), .update_weight_ram(update_weight_ram),
        .update_weight_ram_addr(update_weight_ram_addr), .src(src),
        .weight_data(weight_data), .write_weight_data_addr(write_weight_data_addr),
        .weight_wr_en(weight_wr_en), .weight_data_done(weight_data_done),
        .all_groups_loaded(all_groups_loaded), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [SW-1:0] d;
    } wr_t;

    wr_t sb[$];
    int  compared = 0, mismatched = 0, nwrites = 0;
    int  m_group = 0, m_total = 1;
    bit  m_all = 0;

    function automatic logic [SW-1:0] rnd_slice();
        logic [SW-1:0] r;
        for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Every write strobe must match the oldest accepted beat.
    always @(negedge clk) begin
        wr_t e;
        if (weight_wr_en === 1'b1) begin
            nwrites++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write addr=%h", write_weight_data_addr);
            end else begin
                e = sb.pop_front();
                if (write_weight_data_addr !== {e.a1, e.a0} || weight_data !== e.d) begin
                    mismatched++;
                    $display("FAIL write addr=%h exp_addr=%h data=%h exp_data=%h",
                             write_weight_data_addr, {e.a1, e.a0}, weight_data, e.d);
                end
            end
        end
    end

    task automatic do_load(input bit is_init, input bit both, input bit poke,
                           input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                           input int depth, input int stall_at, input int stall_len);
        int grp, cyc, pushed, w0;
        bit exp_all;
        logic [AW-1:0] base0, base1;
        wr_t e;
        if (is_init) begin
            grp = 0; base0 = '0; base1 = '0;
            m_total = (kernel_num == 0) ? 1 : (int'(kernel_num) + PK - 1) / PK;
        end else begin
            grp = m_group + 1; base0 = b0; base1 = b1;
        end
        exp_all = (grp == m_total - 1);
        w0 = nwrites;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL pre_trigger_busy got=%b exp=0", busy); end
        init_start = is_init;
        update_weight_ram = !is_init || both;
        update_weight_ram_addr = {b1, b0};
        fm_depth = depth[DEPW-1:0];
        @(negedge clk);
        init_start = 1'b0; update_weight_ram = 1'b0;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL post_trigger_busy got=%b exp=1", busy); end
        cyc = 0; pushed = 0;
        while (pushed < depth && cyc < 64) begin
            compared++;
            if (src.ready !== 1'b1) begin mismatched++; $display("FAIL load_ready cyc=%0d got=%b exp=1", cyc, src.ready); end
            src.valid = !(cyc >= stall_at && cyc < stall_at + stall_len);
            src.data  = rnd_slice();
            init_start = poke && cyc == 1;
            update_weight_ram = poke && cyc == 1;
            if (src.valid && src.ready) begin
                compared++;
                if (src.slice !== pushed[DEPW-1:0] || src.group !== grp[KNW-1:0]) begin
                    mismatched++;
                    $display("FAIL src_index slice=%0d exp=%0d group=%0d exp=%0d",
                             src.slice, pushed, src.group, grp);
                end
                e.a0 = base0 + AW'(pushed);
                e.a1 = base1 + AW'(pushed);
                e.d  = src.data;
                sb.push_back(e);
                pushed++;
            end
            @(negedge clk);
            cyc++;
        end
        src.valid = 1'b0; init_start = 1'b0; update_weight_ram = 1'b0;
        compared++;
        if (src.ready !== 1'b0 || weight_data_done !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL finish_cycle ready=%b done=%b busy=%b exp 0/0/1", src.ready, weight_data_done, busy);
        end
        @(negedge clk);
        compared++;
        if (weight_data_done !== 1'b1 || busy !== 1'b0 || weight_wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL done_cycle done=%b busy=%b wr_en=%b exp 1/0/0", weight_data_done, busy, weight_wr_en);
        end
        compared++;
        if (all_groups_loaded !== exp_all) begin
            mismatched++;
            $display("FAIL all_groups_loaded got=%b exp=%b", all_groups_loaded, exp_all);
        end
        compared++;
        if (nwrites - w0 != depth) begin
            mismatched++;
            $display("FAIL write_count got=%0d exp=%0d", nwrites - w0, depth);
        end
        m_group = grp; m_all = exp_all;
    endtask

    task automatic check_idle_zero(input string tag);
        compared++;
        if (busy !== 1'b0 || weight_wr_en !== 1'b0 || weight_data_done !== 1'b0 ||
            all_groups_loaded !== 1'b0 || src.ready !== 1'b0 || weight_data !== '0 ||
            write_weight_data_addr !== '0 || src.group !== '0 || src.slice !== '0) begin
            mismatched++;
            $display("FAIL %s busy=%b wr=%b done=%b all=%b ready=%b addr=%h grp=%0d slc=%0d exp all zero",
                     tag, busy, weight_wr_en, weight_data_done, all_groups_loaded, src.ready,
                     write_weight_data_addr, src.group, src.slice);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_state");
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("idle_after_reset");
    endtask

    task automatic test_initial_load();
        kernel_num = 8'd4;
        do_load(1'b1, 1'b0, 1'b0, '0, '0, 2, 99, 0);
    endtask

    task automatic test_group_update();
        do_load(1'b0, 1'b0, 1'b0, 10'd18, 10'd18, 2, 99, 0);
    endtask

    task automatic test_update_ignored();
        int w0;
        w0 = nwrites;
        update_weight_ram = 1'b1;
        update_weight_ram_addr = {10'd40, 10'd40};
        fm_depth = 6'd2;
        repeat (4) begin
            @(negedge clk);
            compared++;
            if (src.ready !== 1'b0 || busy !== 1'b0 || weight_data_done !== 1'b1) begin
                mismatched++;
                $display("FAIL update_ignored ready=%b busy=%b done=%b exp 0/0/1", src.ready, busy, weight_data_done);
            end
        end
        update_weight_ram = 1'b0;
        compared++;
        if (nwrites != w0) begin mismatched++; $display("FAIL update_ignored_writes got=%0d exp=0", nwrites - w0); end
    endtask

    task automatic test_simultaneous();
        kernel_num = 8'd6;
        do_load(1'b1, 1'b1, 1'b1, 10'd5, 10'd7, 3, 99, 0);
    endtask

    task automatic test_wrap();
        do_load(1'b0, 1'b0, 1'b0, 10'd1023, 10'd500, 2, 99, 0);
    endtask

    task automatic test_backpressure();
        kernel_num = 8'd2;
        do_load(1'b1, 1'b0, 1'b0, '0, '0, 3, 1, 2);
    endtask

    task automatic test_reset_midload();
        wr_t e;
        kernel_num = 8'd4;
        @(negedge clk);
        init_start = 1'b1; fm_depth = 6'd4;
        @(negedge clk);
        init_start = 1'b0;
        src.valid = 1'b1; src.data = rnd_slice();
        e.a0 = '0; e.a1 = '0; e.d = src.data;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0; src.valid = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_midload");
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_midload_hold");
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL reset_midload_pending got=%0d exp=0", sb.size()); end
        m_group = 0; m_all = 0;
        do_load(1'b1, 1'b0, 1'b0, '0, '0, 2, 99, 0);
        do_load(1'b0, 1'b0, 1'b0, 10'd100, 10'd200, 0, 99, 0);
    endtask

    initial begin
        src.valid = 1'b0;
        src.data  = '0;
        test_reset();
        test_initial_load();
        test_group_update();
        test_update_ignored();
        test_simultaneous();
        test_wrap();
        test_backpressure();
        test_reset_midload();
        repeat (3) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL leftover_beats got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", compared);
        $fatal(1, "timeout");
    end
endmodule
